// File: rtl/count_event_logger.sv
// Watches an up/down counter and queues LOAD / WRAP_UP / WRAP_DN records in a small FIFO.
// Define COUNT_EVENT_TIMESTAMP_EN to prepend an 8-bit cycle timestamp to every record.
module count_event_logger #(
  parameter int DEPTH = 8,
  parameter int CW    = 4,
  localparam int AW   = $clog2(DEPTH),
`ifdef COUNT_EVENT_TIMESTAMP_EN
  localparam int RW   = CW + 10
`else
  localparam int RW   = CW + 2
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cnt_in,
  input  logic          load_in,
  input  logic          updn_in,
  input  logic          evt_ready,
  input  logic          ovf_clr,
  output logic          evt_valid,
  output logic [RW-1:0] evt_data,
  output logic [AW:0]   evt_level,
  output logic          evt_ovf
);

  localparam logic       S_IDLE   = 1'b0;
  localparam logic       S_ARMED  = 1'b1;
  localparam logic [1:0] T_LOAD   = 2'b11;
  localparam logic [1:0] T_WRAPUP = 2'b01;
  localparam logic [1:0] T_WRAPDN = 2'b10;
  localparam logic [CW-1:0] ALL_ONES = '1;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  logic          r_state;
  logic [CW-1:0] r_prev;
  logic          r_ld;
  logic          r_ud;
  logic [RW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          r_ovf;

  logic          w_evt;
  logic [1:0]    w_type;
  logic [RW-1:0] w_rec;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_prev  <= '0;
      r_ld    <= 1'b0;
      r_ud    <= 1'b0;
    end else begin
      r_state <= S_ARMED;
      r_prev  <= cnt_in;
      r_ld    <= load_in;
      r_ud    <= updn_in;
    end
  end

  // A load dominates any coincidental wrap, since the counter value then comes from the load.
  always_comb begin
    w_evt  = 1'b0;
    w_type = 2'b00;
    if (r_state == S_ARMED) begin
      if (r_ld) begin
        w_evt  = 1'b1;
        w_type = T_LOAD;
      end else if (r_ud && (r_prev == ALL_ONES) && (cnt_in == '0)) begin
        w_evt  = 1'b1;
        w_type = T_WRAPUP;
      end else if (!r_ud && (r_prev == '0) && (cnt_in == ALL_ONES)) begin
        w_evt  = 1'b1;
        w_type = T_WRAPDN;
      end
    end
  end

`ifdef COUNT_EVENT_TIMESTAMP_EN
  logic [7:0] r_ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + 8'd1;
  end

  assign w_rec = {r_ts, w_type, cnt_in};
`else
  assign w_rec = {w_type, cnt_in};
`endif

  // A pop on the same edge frees a slot, so a full FIFO can still accept the new record.
  assign w_full = (r_level == FULL_LVL);
  assign w_pop  = (r_level != '0) && evt_ready;
  assign w_push = w_evt && (!w_full || w_pop);
  assign w_drop = w_evt && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_rec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  // Memory is not reset, so the head is masked to zero while the FIFO is empty.
  assign evt_valid = (r_level != '0);
  assign evt_data  = evt_valid ? r_mem[r_rptr] : '0;
  assign evt_level = r_level;
  assign evt_ovf   = r_ovf;

endmodule

// File: tb/tb_count_event_logger.sv
// Self-checking bench for count_event_logger: queue-based reference model plus directed scenarios.
module tb_count_event_logger;

  localparam int DEPTH = 8;
  localparam int CW    = 4;
`ifdef COUNT_EVENT_TIMESTAMP_EN
  localparam int TSW = 8;
`else
  localparam int TSW = 0;
`endif
  localparam int RW = CW + 2 + TSW;

  logic          clk;
  logic          rst;
  logic [CW-1:0] cnt_in;
  logic          load_in;
  logic          updn_in;
  logic          evt_ready;
  logic          ovf_clr;
  logic          evt_valid;
  logic [RW-1:0] evt_data;
  logic [3:0]    evt_level;
  logic          evt_ovf;

  int passCount;
  int checkCount;

  count_event_logger #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .load_in(load_in), .updn_in(updn_in),
    .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(evt_valid),
    .evt_data(evt_data), .evt_level(evt_level), .evt_ovf(evt_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the FIFO is a plain queue, events follow the detection rules directly.
  logic [RW-1:0] mq[$];
  logic          mOvf;
  logic [CW-1:0] mPrev;
  logic          mLd;
  logic          mUd;
  logic          mArmed;
  int            mTs;
  bit            mHasEvt;
  logic [1:0]    mType;
  bit            mPop;
  bit            mDrop;
  int            mSize;
  logic [RW-1:0] mRec;

  initial begin
    mOvf = 1'b0; mPrev = '0; mLd = 1'b0; mUd = 1'b0; mArmed = 1'b0; mTs = 0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mOvf = 1'b0; mPrev = '0; mLd = 1'b0; mUd = 1'b0; mArmed = 1'b0; mTs = 0;
    end else begin
      mHasEvt = 1'b0;
      mType   = 2'b00;
      if (mArmed) begin
        if (mLd) begin
          mHasEvt = 1'b1; mType = 2'b11;
        end else if (mUd && mPrev == CW'(2**CW - 1) && cnt_in == 0) begin
          mHasEvt = 1'b1; mType = 2'b01;
        end else if (!mUd && mPrev == 0 && cnt_in == CW'(2**CW - 1)) begin
          mHasEvt = 1'b1; mType = 2'b10;
        end
      end
      mRec  = RW'({mTs[7:0], mType, cnt_in});
      mSize = mq.size();
      mPop  = (mSize > 0) && evt_ready;
      mDrop = mHasEvt && (mSize == DEPTH) && !mPop;
      if (mPop) void'(mq.pop_front());
      if (mHasEvt && !mDrop) mq.push_back(mRec);
      if (mDrop) mOvf = 1'b1;
      else if (ovf_clr) mOvf = 1'b0;
      mPrev = cnt_in; mLd = load_in; mUd = updn_in; mArmed = 1'b1;
      mTs = (mTs + 1) % 256;
    end
  end

  // Compare every cycle on the falling edge, and log records the consumer takes.
  logic [CW+1:0] popLog[$];

  always @(negedge clk) begin
    checkOutput("evt_valid", 32'(evt_valid), 32'(mq.size() != 0));
    checkOutput("evt_data",  32'(evt_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    checkOutput("evt_level", 32'(evt_level), 32'(mq.size()));
    checkOutput("evt_ovf",   32'(evt_ovf),   32'(mOvf));
    if (evt_valid && evt_ready) popLog.push_back(evt_data[CW+1:0]);
  end

  task automatic applyStimulus(input logic [CW-1:0] cnt, input logic ld, input logic ud,
                               input logic rdy, input logic clr);
    cnt_in = cnt; load_in = ld; updn_in = ud; evt_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    passCount = 0; checkCount = 0;
    rst = 1'b1; cnt_in = '0; load_in = 1'b0; updn_in = 1'b1; evt_ready = 1'b1; ovf_clr = 1'b0;
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("reset_valid", 32'(evt_valid), 32'd0);
    checkOutput("reset_data",  32'(evt_data),  32'd0);
    checkOutput("reset_level", 32'(evt_level), 32'd0);
    checkOutput("reset_ovf",   32'(evt_ovf),   32'd0);

    // Free-running up count through one wrap.
    rst = 1'b0;
    popLog.delete();
    for (int i = 0; i < 18; i++) applyStimulus(CW'(i % 16), 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("wrapup_count", 32'(popLog.size()), 32'd1);
    if (popLog.size() > 0) checkOutput("wrapup_rec", 32'(popLog[0]), 32'h10);

    // Load 5, then count down through zero.
    popLog.delete();
    applyStimulus(4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int v = 5; v >= 0; v--) applyStimulus(CW'(v), 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'd15, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'd14, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'd13, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("load_count", 32'(popLog.size()), 32'd2);
    if (popLog.size() > 1) begin
      checkOutput("load_rec",   32'(popLog[0]), 32'h35);
      checkOutput("wrapdn_rec", 32'(popLog[1]), 32'h2f);
    end

    // Nine wraps with the consumer stalled: overflow.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'd0,  1'b0, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("full_level", 32'(evt_level), 32'd8);
    checkOutput("full_ovf",   32'(evt_ovf),   32'd1);
    applyStimulus(4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("ovf_clr", 32'(evt_ovf), 32'd0);

    // Push and pop together while full.
    applyStimulus(4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'd0,  1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("pushpop_level", 32'(evt_level), 32'd8);
    checkOutput("pushpop_ovf",   32'(evt_ovf),   32'd0);
    for (int k = 0; k < 10; k++) applyStimulus(4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("drain_level", 32'(evt_level), 32'd0);

    // Three queued events, then an asynchronous reset mid-cycle.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'd0,  1'b0, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("queued_level", 32'(evt_level), 32'd3);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_valid", 32'(evt_valid), 32'd0);
    checkOutput("async_level", 32'(evt_level), 32'd0);
    applyStimulus(4'd15, 1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    applyStimulus(4'd15, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("first_edge_quiet", 32'(evt_valid), 32'd0);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'd1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Random traffic, biased toward the wrap values.
    for (int n = 0; n < 3000; n++) begin
      logic [CW-1:0] c;
      case ($urandom_range(0, 3))
        0:       c = '0;
        1:       c = '1;
        default: c = CW'($urandom);
      endcase
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus(c, $urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 2) == 0,
                    $urandom_range(0, 15) == 0);
    end
    rst = 1'b0;
    applyStimulus(4'd1, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/count_event_logger.md
COUNT_EVENT_LOGGER -- requirements
Module: count_event_logger

Interface
REQ-001 Parameter DEPTH, 8, event FIFO depth; SHALL be a power of 2, minimum 2.
REQ-002 Parameter CW, 4, counter value width; SHALL match the upstream up/down counter's data_out width.
REQ-003 Port clk  input  1  single rising-edge clock.
REQ-004 Port rst  input  1  reset; asynchronous and active-high.
REQ-005 Port cnt_in  input  CW  counter data_out, sampled every clk.
REQ-006 Port load_in  input  1  counter load control as driven to the counter.
REQ-007 Port updn_in  input  1  counter direction as driven to the counter; 1=up, 0=down.
REQ-008 Port evt_ready  input  1  consumer accepts the head record.
REQ-009 Port ovf_clr  input  1  clears the sticky overflow flag.
REQ-010 Port evt_valid  output  1  FIFO non-empty; head record on evt_data.
REQ-011 Port evt_data  output  RW  head record {type[1:0], value[CW-1:0]} (RW defined in Configuration).
REQ-012 Port evt_level  output  log2(DEPTH)+1  FIFO occupancy.
REQ-013 Port evt_ovf  output  1  sticky flag: at least one event dropped.

Function
REQ-014 Every clk edge SHALL register prev_q<=cnt_in, ld_q<=load_in, ud_q<=updn_in.
REQ-015 Two-state arming FSM: IDLE after reset, ARMED after first sampling edge; detection SHALL occur only in ARMED.
REQ-016 In ARMED, LOAD (type 2'b11) SHALL be detected when ld_q=1, regardless of value change.
REQ-017 In ARMED, WRAP_UP (type 2'b01) SHALL be detected when ld_q=0, ud_q=1, prev_q=all-ones, cnt_in=0.
REQ-018 In ARMED, WRAP_DN (type 2'b10) SHALL be detected when ld_q=0, ud_q=0, prev_q=0, cnt_in=all-ones.
REQ-019 Type 2'b00 SHALL never be emitted; priority LOAD > WRAP_UP > WRAP_DN; at most one event per cycle.
REQ-020 Record value field SHALL be cnt_in at detection.
REQ-021 A detected event SHALL be written at the detection edge; evt_valid SHALL rise the following cycle (1-cycle latency).
REQ-022 Pop SHALL occur on an edge where evt_valid=1 and evt_ready=1; evt_data SHALL stay stable while evt_valid=1 and evt_ready=0.
REQ-023 Push when full without simultaneous pop: event SHALL be dropped, FIFO unchanged, evt_ovf set.
REQ-024 Push and pop on the same edge when full SHALL both succeed; level unchanged; no overflow.
REQ-025 Push and pop on the same edge when empty: pop ignored (evt_valid=0), push succeeds.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; evt_level SHALL equal pushes minus pops, range 0..DEPTH.
REQ-027 ovf_clr SHALL clear evt_ovf next edge; if an overflow occurs on that same edge, evt_ovf SHALL remain 1.

Reset
REQ-028 rst=1 SHALL immediately force evt_valid=0, evt_data=0, evt_level=0, evt_ovf=0, pointers=0, prev_q=0, FSM=IDLE, timestamp=0.
REQ-029 Reset mid-operation SHALL discard all stored events; no event SHALL be detected on the first edge after deassertion.

Configuration
REQ-030 Macro COUNT_EVENT_TIMESTAMP_EN defined: 8-bit free-running cycle counter, reset 0, wraps 255->0; record is {ts[7:0], type, value}, RW=CW+10; ts is counter value at detection edge.
REQ-031 Macro undefined: no timestamp logic; RW=CW+2; all other behaviour identical.

Verification
REQ-032 Reset, updn_in=1, counter free-runs 0..15->0, evt_ready=1 -> exactly one WRAP_UP record, value 0, one cycle after cnt_in shows 0.
REQ-033 load_in=1 with data 5 for one cycle, updn_in=0, then count down 5..0->15 -> records LOAD/5 then WRAP_DN/15, in order.
REQ-034 evt_ready=0, DEPTH=8, 9 wrap events -> evt_level=8, evt_ovf=1, popped contents are first 8 events; ovf_clr pulse -> evt_ovf=0.
REQ-035 FIFO full, evt_ready=1 on same edge as a new wrap -> level stays 8, evt_ovf stays 0, new record retained at tail.
REQ-036 rst asserted asynchronously with 3 events queued -> evt_valid and evt_level drop to 0 before next edge; cnt_in at 15 then 0 on first two edges after release -> no event on first edge, WRAP_UP only if prev sample was 15 while ARMED.
REQ-037 With COUNT_EVENT_TIMESTAMP_EN, WRAP_UP at cycle 16 after reset release -> record ts=16; after 256 further cycles, ts field wraps correctly.
